// File: rtl/spi_pkg.sv
// Shared types and sizing for the SPI link (responder and master driver).
package spi_pkg;

    localparam int SPI_MAXLEN_DEF = 16;
    localparam int SPI_CNT_W      = $clog2(SPI_MAXLEN_DEF) + 1;

    typedef enum logic [1:0] {
        WAIT_DESEL,
        IDLE,
        ACTIVE
    } spi_state_t;

    function automatic int cnt_w(input int maxlen);
        return $clog2(maxlen) + 1;
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer with registered-copy rise/fall strobes.
module spi_sync #(
    parameter int   STAGES   = 2,
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic clk,
    input  logic sresetn,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            chain <= {STAGES{IDLE_LVL}};
            prev  <= IDLE_LVL;
        end else begin
            chain[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
            prev <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/spi_rsp.sv
// SPI mode-0 responder: oversampled pins, MSB-first shift, framed rx report.
module spi_rsp
    import spi_pkg::*;
#(
    parameter int SPI_MAXLEN  = SPI_MAXLEN_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        sresetn,
    input  logic                        SCLK,
    input  logic                        SS_N,
    input  logic                        MOSI,
    output logic                        MISO,
    input  logic [SPI_MAXLEN-1:0]       tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic [SPI_MAXLEN-1:0]       rx_data,
    output logic [$clog2(SPI_MAXLEN):0] rx_nbits,
    output logic                        rx_valid,
    output logic                        rx_ovf,
    output logic                        tx_underrun,
    output logic                        busy
);

    localparam int CW = cnt_w(SPI_MAXLEN);
    localparam int MW = SPI_MAXLEN;

    logic sclk_rise, sclk_fall, ss_lvl, ss_rise, ss_fall, mosi_lvl;
    logic [1:0] unused_edges;

    spi_sync #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b0)) u_sclk (
        .clk(clk), .sresetn(sresetn), .din(SCLK),
        .level(unused_edges[0]), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b1)) u_ss (
        .clk(clk), .sresetn(sresetn), .din(SS_N),
        .level(ss_lvl), .rise(ss_rise), .fall(ss_fall)
    );

    logic mosi_r, mosi_f;

    spi_sync #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b0)) u_mosi (
        .clk(clk), .sresetn(sresetn), .din(MOSI),
        .level(mosi_lvl), .rise(mosi_r), .fall(mosi_f)
    );

    assign unused_edges[1] = mosi_r ^ mosi_f;

    // Synchronizer flops reset to idle, so ignore SS_N until the pin has flushed through.
    logic [SYNC_STAGES:0] settle;
    logic                 settled;

    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) settle <= '0;
        else          settle <= {settle[SYNC_STAGES-1:0], 1'b1};
    end

    assign settled = settle[SYNC_STAGES];

    spi_state_t    state, state_n;
    logic [CW-1:0] bit_cnt, bit_cnt_n;
    logic [MW-1:0] rx_shift, rx_shift_n, tx_shift, tx_shift_n;
    logic [MW-1:0] tx_buf, tx_buf_n, rx_data_n;
    logic [CW-1:0] rx_nbits_n;
    logic          ovf, ovf_n, tx_full, tx_full_n, miso_n, busy_n;
    logic          rx_valid_n, rx_ovf_n, tx_underrun_n;

    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            state       <= WAIT_DESEL;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            tx_buf      <= '0;
            tx_full     <= 1'b0;
            ovf         <= 1'b0;
            MISO        <= 1'b0;
            busy        <= 1'b0;
            rx_data     <= '0;
            rx_nbits    <= '0;
            rx_valid    <= 1'b0;
            rx_ovf      <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            rx_shift    <= rx_shift_n;
            tx_shift    <= tx_shift_n;
            tx_buf      <= tx_buf_n;
            tx_full     <= tx_full_n;
            ovf         <= ovf_n;
            MISO        <= miso_n;
            busy        <= busy_n;
            rx_data     <= rx_data_n;
            rx_nbits    <= rx_nbits_n;
            rx_valid    <= rx_valid_n;
            rx_ovf      <= rx_ovf_n;
            tx_underrun <= tx_underrun_n;
        end
    end

    assign tx_ready = ~tx_full;

    always_comb begin
        state_n       = state;
        bit_cnt_n     = bit_cnt;
        rx_shift_n    = rx_shift;
        tx_shift_n    = tx_shift;
        tx_buf_n      = tx_buf;
        tx_full_n     = tx_full;
        ovf_n         = ovf;
        miso_n        = MISO;
        busy_n        = busy;
        rx_data_n     = rx_data;
        rx_nbits_n    = rx_nbits;
        rx_valid_n    = 1'b0;
        rx_ovf_n      = 1'b0;
        tx_underrun_n = 1'b0;

        if (tx_valid && !tx_full) begin
            tx_buf_n  = tx_data;
            tx_full_n = 1'b1;
        end

        unique case (state)
            WAIT_DESEL: begin
                if (settled && ss_lvl) state_n = IDLE;
            end
            IDLE: begin
                if (ss_fall) begin
                    tx_shift_n    = tx_full ? tx_buf : '0;
                    miso_n        = tx_full & tx_buf[MW-1];
                    tx_underrun_n = ~tx_full;
                    if (tx_full) tx_full_n = 1'b0;
                    bit_cnt_n     = '0;
                    rx_shift_n    = '0;
                    ovf_n         = 1'b0;
                    busy_n        = 1'b1;
                    state_n       = ACTIVE;
                end
            end
            ACTIVE: begin
                if (sclk_rise) begin
                    rx_shift_n = {rx_shift[MW-2:0], mosi_lvl};
                    if (bit_cnt < CW'(MW)) bit_cnt_n = bit_cnt + CW'(1);
                    else                   ovf_n     = 1'b1;
                end
                if (sclk_fall) begin
                    tx_shift_n = {tx_shift[MW-2:0], 1'b0};
                    miso_n     = tx_shift[MW-2];
                end
                // Completion sees the bit captured in this same cycle.
                if (ss_rise) begin
                    if (bit_cnt_n != '0) begin
                        rx_data_n  = rx_shift_n;
                        rx_nbits_n = bit_cnt_n;
                        rx_valid_n = 1'b1;
                        rx_ovf_n   = ovf_n;
                    end
                    busy_n  = 1'b0;
                    miso_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = WAIT_DESEL;
        endcase
    end

endmodule

// File: tb/tb_spi_rsp.sv
// Self-checking bench for spi_rsp: vector table, corner sequences, random frames.
module tb_spi_rsp;

    logic        clk = 1'b0;
    logic        sresetn = 1'b0;
    logic        SCLK = 1'b0;
    logic        SS_N = 1'b1;
    logic        MOSI = 1'b0;
    logic        MISO;
    logic [15:0] tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [15:0] rx_data;
    logic [4:0]  rx_nbits;
    logic        rx_valid, rx_ovf, tx_underrun, busy;

    spi_rsp #(.SPI_MAXLEN(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .sresetn(sresetn), .SCLK(SCLK), .SS_N(SS_N),
        .MOSI(MOSI), .MISO(MISO), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_nbits(rx_nbits),
        .rx_valid(rx_valid), .rx_ovf(rx_ovf), .tx_underrun(tx_underrun),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [4:0]  nbits;
        logic        ovf;
    } rx_ev_t;

    rx_ev_t rxq[$];
    int     und_cnt = 0;

    always @(negedge clk) begin
        if (rx_valid) rxq.push_back('{rx_data, rx_nbits, rx_ovf});
        if (tx_underrun) und_cnt++;
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // All tasks enter and leave 1 time unit after a rising clk edge.
    task automatic tx_load(input logic [15:0] w);
        int k = 0;
        tx_data  = w;
        tx_valid = 1'b1;
        while (!tx_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        total++;
        if (k == 20) begin
            bad++;
            $display("FAIL tx_load_timeout: got tx_ready=0 expected 1");
        end
        @(posedge clk); #1;
        tx_valid = 1'b0;
    endtask

    task automatic spi_bits(input logic [31:0] w, input int n, output logic [31:0] mo);
        mo = '0;
        for (int i = 0; i < n; i++) begin
            mo   = {mo[30:0], MISO};
            SCLK = 1'b1;
            repeat (4) @(posedge clk);
            #1;
            SCLK = 1'b0;
            if (i + 1 < n) MOSI = w[n-2-i];
            repeat (4) @(posedge clk);
            #1;
        end
    endtask

    task automatic spi_frame(input logic [31:0] w, input int n, output logic [31:0] mo);
        SS_N = 1'b0;
        if (n > 0) MOSI = w[n-1];
        repeat (4) @(posedge clk);
        #1;
        spi_bits(w, n, mo);
        SS_N = 1'b1;
        MOSI = 1'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    typedef struct {
        string       name;
        int          n;
        logic [31:0] mosi;
        logic        ld;
        logic [15:0] tx;
        int          exp_nvalid;
        logic [15:0] exp_data;
        logic [4:0]  exp_nbits;
        logic        exp_ovf;
        logic [31:0] exp_miso;
        int          exp_und;
    } vec_t;

    vec_t vecs[$];

    // Reference: what a responder should return for one frame, from the frame rules.
    task automatic run_frame(input string nm, input int n, input logic [31:0] w,
                             input logic ld, input logic [15:0] tx,
                             input int env, input logic [15:0] ed,
                             input logic [4:0] enb, input logic eo,
                             input logic [31:0] em, input int eu);
        int          q0, u0;
        logic [31:0] mo, mask;
        q0 = rxq.size();
        u0 = und_cnt;
        if (ld) tx_load(tx);
        spi_frame(w, n, mo);
        mask = (n >= 32) ? '1 : ((32'd1 << n) - 1);
        chk({nm, ".nvalid"}, rxq.size() - q0, env);
        chk({nm, ".underrun"}, und_cnt - u0, eu);
        chk({nm, ".miso"}, mo & mask, em & mask);
        if (env == 1 && rxq.size() == q0 + 1) begin
            chk({nm, ".data"}, rxq[q0].data, ed);
            chk({nm, ".nbits"}, rxq[q0].nbits, enb);
            chk({nm, ".ovf"}, rxq[q0].ovf, eo);
        end
    endtask

    initial begin
        logic [31:0] mo;
        int          q0, u0;

        vecs.push_back('{"basic16", 16, 32'h3C5A, 1'b1, 16'hA5C3,
                         1, 16'h3C5A, 5'd16, 1'b0, 32'hA5C3, 0});
        vecs.push_back('{"short8", 8, 32'h81, 1'b1, 16'hF00F,
                         1, 16'h0081, 5'd8, 1'b0, 32'hF0, 0});
        vecs.push_back('{"underrun", 16, 32'h1234, 1'b0, 16'h0,
                         1, 16'h1234, 5'd16, 1'b0, 32'h0, 1});
        vecs.push_back('{"ovf20", 20, 32'hABCDE, 1'b0, 16'h0,
                         1, 16'hBCDE, 5'd16, 1'b1, 32'h0, 1});
        vecs.push_back('{"one_bit", 1, 32'h1, 1'b1, 16'h8000,
                         1, 16'h0001, 5'd1, 1'b0, 32'h1, 0});
        vecs.push_back('{"empty", 0, 32'h0, 1'b1, 16'h1111,
                         0, 16'h0, 5'd0, 1'b0, 32'h0, 0});
        vecs.push_back('{"ovf17", 17, 32'h10001, 1'b1, 16'hFFFF,
                         1, 16'h0001, 5'd16, 1'b1, 32'h1FFFE, 0});

        repeat (3) @(posedge clk);
        #1;
        chk("rst.miso", MISO, 0);
        chk("rst.tx_ready", tx_ready, 1);
        chk("rst.rx_data", rx_data, 0);
        chk("rst.rx_nbits", rx_nbits, 0);
        chk("rst.rx_valid", rx_valid, 0);
        chk("rst.rx_ovf", rx_ovf, 0);
        chk("rst.underrun", tx_underrun, 0);
        chk("rst.busy", busy, 0);
        sresetn = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            run_frame(vecs[i].name, vecs[i].n, vecs[i].mosi, vecs[i].ld,
                      vecs[i].tx, vecs[i].exp_nvalid, vecs[i].exp_data,
                      vecs[i].exp_nbits, vecs[i].exp_ovf, vecs[i].exp_miso,
                      vecs[i].exp_und);
        end

        // Reset in the middle of a frame, released with SS_N still low.
        q0 = rxq.size();
        SS_N = 1'b0;
        MOSI = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        spi_bits(32'h1F, 5, mo);
        sresetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        sresetn = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        spi_bits(32'h5, 3, mo);
        chk("midrst.busy", busy, 0);
        chk("midrst.miso", mo, 0);
        SS_N = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("midrst.nvalid", rxq.size() - q0, 0);
        chk("midrst.rx_data", rx_data, 0);
        run_frame("after_rst", 16, 32'hBEEF, 1'b0, 16'h0,
                  1, 16'hBEEF, 5'd16, 1'b0, 32'h0, 1);

        // Empty frame consumes the buffer; a load during the frame feeds the next.
        q0 = rxq.size();
        u0 = und_cnt;
        tx_load(16'h2468);
        chk("hold.tx_ready", tx_ready, 0);
        SS_N = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("start.tx_ready", tx_ready, 1);
        chk("start.busy", busy, 1);
        tx_load(16'h1357);
        chk("mid.tx_ready", tx_ready, 0);
        SS_N = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("noedge.nvalid", rxq.size() - q0, 0);
        chk("noedge.busy", busy, 0);
        chk("noedge.underrun", und_cnt - u0, 0);
        run_frame("next_frame", 16, 32'h0F0F, 1'b0, 16'h0,
                  1, 16'h0F0F, 5'd16, 1'b0, 32'h1357, 0);

        for (int r = 0; r < 30; r++) begin
            int          n, nb;
            logic [31:0] w, em;
            logic        ld;
            logic [15:0] tx;
            n  = $urandom_range(0, 24);
            w  = $urandom;
            ld = ($urandom_range(0, 3) != 0);
            tx = 16'($urandom);
            nb = (n > 16) ? 16 : n;
            em = '0;
            for (int i = 0; i < n; i++) begin
                em = {em[30:0], (ld && i < 16) ? tx[15-i] : 1'b0};
            end
            run_frame("rand", n, w, ld, tx, (n > 0) ? 1 : 0,
                      16'(w & ((32'd1 << nb) - 1)), 5'(nb), (n > 16),
                      em, ld ? 0 : 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
